// File: rtl/oa_fifo_icb_writer.sv
// OA FIFO drain: turns packed 32-bit activation words into strided ICB writes,
// tracking outstanding responses and reporting done/err to the EAI control FSM.
`timescale 1ns/1ps
module oa_fifo_icb_writer #(
    parameter int VLEN    = 16,
    parameter int MAX_OUT = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_start,
    input  logic [31:0]            cfg_base_addr,
    input  logic [15:0]            cfg_row_stride,
    input  logic [$clog2(VLEN):0]  cfg_num_rows,
    input  logic [VLEN/4-1:0]      cfg_valid_num_col,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic                   oa_fifo_req,
    output logic [VLEN/4-1:0]      vec_valid_num_col,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_row_switch,
    input  logic [3:0]             in_mask,
    input  logic [31:0]            in_data,
    output logic                   icb_cmd_valid,
    input  logic                   icb_cmd_ready,
    output logic [31:0]            icb_cmd_addr,
    output logic                   icb_cmd_read,
    output logic [31:0]            icb_cmd_wdata,
    output logic [3:0]             icb_cmd_wmask,
    input  logic                   icb_rsp_valid,
    output logic                   icb_rsp_ready,
    input  logic                   icb_rsp_err
);

    localparam int ROWW = $clog2(VLEN) + 1;
    localparam int COLW = $clog2(VLEN/4) + 1;
    localparam int OUTW = $clog2(MAX_OUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic               r_err;
    logic [VLEN/4-1:0]  r_vnc;
    logic [31:0]        r_row_addr;
    logic [15:0]        r_stride;
    logic [ROWW-1:0]    r_num_rows;
    logic [ROWW-1:0]    r_row_cnt;
    logic [COLW-1:0]    r_col_cnt;
    logic [OUTW-1:0]    r_out_cnt;

    logic               w_run;
    logic               w_can_issue;
    logic               w_mask_nz;
    logic               w_accept;
    logic               w_cmd_fire;
    logic               w_rsp_dec;
    logic               w_row_last;
    logic [OUTW-1:0]    w_out_nxt;
    logic               w_unused;

    // oa_fifo_req is informational only; the valid/ready handshake governs transfer
    assign w_unused = oa_fifo_req;

    assign w_run       = (r_state == S_RUN);
    assign w_can_issue = w_run && (r_out_cnt < OUTW'(MAX_OUT));
    assign w_mask_nz   = |in_mask;

    // Fully masked words never reach the bus, so they bypass the outstanding limit
    assign icb_cmd_valid = w_mask_nz & in_valid & w_can_issue;
    assign in_ready      = w_mask_nz ? (w_can_issue & icb_cmd_ready) : w_run;

    assign w_accept   = in_valid & in_ready;
    assign w_cmd_fire = icb_cmd_valid & icb_cmd_ready;
    assign w_rsp_dec  = icb_rsp_valid && (r_out_cnt != '0);
    assign w_out_nxt  = r_out_cnt + OUTW'(w_cmd_fire) - OUTW'(w_rsp_dec);
    assign w_row_last = (r_row_cnt + ROWW'(1)) == r_num_rows;

    assign icb_cmd_addr  = r_row_addr + 32'({r_col_cnt, 2'b00});
    assign icb_cmd_read  = 1'b0;
    assign icb_cmd_wdata = in_data;
    assign icb_cmd_wmask = in_mask;
    assign icb_rsp_ready = 1'b1;

    assign busy              = r_busy;
    assign done              = r_done;
    assign err               = r_err;
    assign vec_valid_num_col = r_vnc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_vnc      <= '0;
            r_row_addr <= '0;
            r_stride   <= '0;
            r_num_rows <= '0;
            r_row_cnt  <= '0;
            r_col_cnt  <= '0;
            r_out_cnt  <= '0;
        end else begin
            r_out_cnt <= w_out_nxt;
            if (r_busy && icb_rsp_valid && icb_rsp_err)
                r_err <= 1'b1;

            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_err      <= 1'b0;
                        r_vnc      <= cfg_valid_num_col;
                        r_row_addr <= cfg_base_addr;
                        r_stride   <= cfg_row_stride;
                        r_num_rows <= cfg_num_rows;
                        r_row_cnt  <= '0;
                        r_col_cnt  <= '0;
                        if (cfg_num_rows == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_RUN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        if (in_row_switch) begin
                            r_row_addr <= r_row_addr + 32'(r_stride);
                            r_col_cnt  <= '0;
                            r_row_cnt  <= r_row_cnt + ROWW'(1);
                            if (w_row_last)
                                r_state <= S_DRAIN;
                        end else begin
                            r_col_cnt <= r_col_cnt + COLW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_out_nxt == '0) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_done  <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_oa_fifo_icb_writer.sv
// Scoreboard bench for oa_fifo_icb_writer: queued upstream words, expected ICB
// commands checked in order as they fire, bench-controlled response channel.
`timescale 1ns/1ps
module tb_oa_fifo_icb_writer;

    localparam int VLEN    = 16;
    localparam int MAX_OUT = 4;
    localparam int NRW     = $clog2(VLEN) + 1;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              cfg_start = 1'b0;
    logic [31:0]       cfg_base_addr = '0;
    logic [15:0]       cfg_row_stride = '0;
    logic [NRW-1:0]    cfg_num_rows = '0;
    logic [VLEN/4-1:0] cfg_valid_num_col = '0;
    logic              busy, done, err;
    logic              oa_fifo_req = 1'b0;
    logic [VLEN/4-1:0] vec_valid_num_col;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              in_row_switch = 1'b0;
    logic [3:0]        in_mask = '0;
    logic [31:0]       in_data = '0;
    logic              icb_cmd_valid;
    logic              icb_cmd_ready = 1'b1;
    logic [31:0]       icb_cmd_addr;
    logic              icb_cmd_read;
    logic [31:0]       icb_cmd_wdata;
    logic [3:0]        icb_cmd_wmask;
    logic              icb_rsp_valid = 1'b0;
    logic              icb_rsp_ready;
    logic              icb_rsp_err = 1'b0;

    always #5 clk = ~clk;

    oa_fifo_icb_writer #(.VLEN(VLEN), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start),
        .cfg_base_addr(cfg_base_addr), .cfg_row_stride(cfg_row_stride),
        .cfg_num_rows(cfg_num_rows), .cfg_valid_num_col(cfg_valid_num_col),
        .busy(busy), .done(done), .err(err),
        .oa_fifo_req(oa_fifo_req), .vec_valid_num_col(vec_valid_num_col),
        .in_valid(in_valid), .in_ready(in_ready), .in_row_switch(in_row_switch),
        .in_mask(in_mask), .in_data(in_data),
        .icb_cmd_valid(icb_cmd_valid), .icb_cmd_ready(icb_cmd_ready),
        .icb_cmd_addr(icb_cmd_addr), .icb_cmd_read(icb_cmd_read),
        .icb_cmd_wdata(icb_cmd_wdata), .icb_cmd_wmask(icb_cmd_wmask),
        .icb_rsp_valid(icb_rsp_valid), .icb_rsp_ready(icb_rsp_ready),
        .icb_rsp_err(icb_rsp_err)
    );

    typedef struct { logic [31:0] d; logic [3:0] m; logic rs; } word_t;
    typedef struct { logic [31:0] addr; logic [31:0] data; logic [3:0] mask; } cmd_t;

    word_t wq[$];
    cmd_t  exp_q[$];

    int total = 0;
    int bad = 0;
    int acc_cnt = 0, fire_cnt = 0, rsp_cnt = 0, ncyc = 0, last_rsp_cyc = 0;
    int err_idx = -1;
    bit rsp_en = 1'b0;
    bit chk_lat = 1'b0;

    logic [31:0] m_base, m_stride;
    int m_row, m_col;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    // Upstream word source and response channel, both driven just after the clock edge
    always @(posedge clk) begin
        #1;
        if (acc_cnt < wq.size()) begin
            in_valid      = 1'b1;
            in_data       = wq[acc_cnt].d;
            in_mask       = wq[acc_cnt].m;
            in_row_switch = wq[acc_cnt].rs;
        end else begin
            in_valid      = 1'b0;
            in_mask       = '0;
            in_row_switch = 1'b0;
        end
        oa_fifo_req   = in_valid;
        icb_rsp_valid = rsp_en && (fire_cnt > rsp_cnt);
        icb_rsp_err   = icb_rsp_valid && (rsp_cnt == err_idx);
    end

    // Handshake monitor and in-order scoreboard
    always @(negedge clk) begin
        ncyc++;
        if (chk_lat && done)
            check("done_lat", 32'(ncyc - last_rsp_cyc), 32'd1);
        if (in_valid && in_ready)
            acc_cnt++;
        if (icb_cmd_valid && icb_cmd_ready) begin
            if (fire_cnt < exp_q.size()) begin
                check("cmd_addr",  icb_cmd_addr,        exp_q[fire_cnt].addr);
                check("cmd_wdata", icb_cmd_wdata,       exp_q[fire_cnt].data);
                check("cmd_wmask", 32'(icb_cmd_wmask),  32'(exp_q[fire_cnt].mask));
            end else begin
                check("cmd_extra", 32'(fire_cnt), 32'(exp_q.size()));
            end
            fire_cnt++;
        end
        if (icb_rsp_valid) begin
            rsp_cnt++;
            last_rsp_cyc = ncyc;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic start_job(input logic [31:0] base, input logic [15:0] stride,
                             input int rows, input logic [3:0] vnc);
        m_base = base;
        m_stride = 32'(stride);
        m_row = 0;
        m_col = 0;
        cfg_base_addr = base;
        cfg_row_stride = stride;
        cfg_num_rows = NRW'(rows);
        cfg_valid_num_col = vnc;
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
    endtask

    task automatic push_word(input logic [31:0] d, input logic [3:0] m, input logic rs);
        word_t w;
        cmd_t  c;
        w.d = d; w.m = m; w.rs = rs;
        wq.push_back(w);
        if (m != 4'h0) begin
            c.addr = m_base + m_stride * 32'(m_row) + 32'(m_col) * 32'd4;
            c.data = d;
            c.mask = m;
            exp_q.push_back(c);
        end
        if (rs) begin
            m_row++;
            m_col = 0;
        end else begin
            m_col++;
        end
    endtask

    task automatic wait_done(input string tag, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (done) break;
            step();
        end
        check(tag, 32'(done), 32'd1);
    endtask

    task automatic wait_fires(input string tag, input int target, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (fire_cnt >= target) break;
            step();
        end
        check(tag, 32'(fire_cnt), 32'(target));
    endtask

    initial begin
        int f0, a0;
        logic [3:0] mk [4];
        mk[0] = 4'hF; mk[1] = 4'hF; mk[2] = 4'h7; mk[3] = 4'h0;

        step(); step();
        check("rst_busy",  32'(busy), 32'd0);
        check("rst_done",  32'(done), 32'd0);
        check("rst_err",   32'(err),  32'd0);
        check("rst_rdy",   32'(in_ready), 32'd0);
        check("rst_cmdv",  32'(icb_cmd_valid), 32'd0);
        check("rst_vnc",   32'(vec_valid_num_col), 32'd0);
        check("tie_read",  32'(icb_cmd_read), 32'd0);
        check("tie_rrdy",  32'(icb_rsp_ready), 32'd1);
        rst = 1'b0;
        step();

        // T1: two full rows, immediate responses
        f0 = fire_cnt; a0 = acc_cnt; rsp_en = 1'b1;
        start_job(32'h1000, 16'h40, 2, 4'hA);
        cfg_valid_num_col = 4'h5;
        check("t1_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) push_word($urandom, 4'hF, (i % 4) == 3);
        chk_lat = 1'b1;
        wait_done("t1_done", 200);
        check("t1_vnc", 32'(vec_valid_num_col), 32'hA);
        check("t1_busy_end", 32'(busy), 32'd0);
        check("t1_fires", 32'(fire_cnt - f0), 32'd8);
        step();
        chk_lat = 1'b0;
        check("t1_pulse", 32'(done), 32'd0);

        // T2: partial and empty masks, row switch on an all-masked word
        f0 = fire_cnt; a0 = acc_cnt;
        start_job(32'h8000, 16'h100, 2, 4'hC);
        for (int r = 0; r < 2; r++)
            for (int c = 0; c < 4; c++) push_word($urandom, mk[c], c == 3);
        wait_done("t2_done", 200);
        check("t2_fires", 32'(fire_cnt - f0), 32'd6);
        check("t2_acc",   32'(acc_cnt - a0), 32'd8);
        step();

        // T4: command backpressure mid-row
        f0 = fire_cnt; a0 = acc_cnt;
        start_job(32'h3000, 16'h10, 1, 4'h3);
        for (int i = 0; i < 4; i++) push_word($urandom, 4'hF, i == 3);
        wait_fires("t4_two", f0 + 2, 50);
        icb_cmd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            check("t4_rdy",   32'(in_ready), 32'd0);
            check("t4_cmdv",  32'(icb_cmd_valid), 32'd1);
            check("t4_addr",  icb_cmd_addr,  32'h3008);
            check("t4_wdata", icb_cmd_wdata, exp_q[f0 + 2].data);
        end
        icb_cmd_ready = 1'b1;
        wait_done("t4_done", 200);
        check("t4_fires", 32'(fire_cnt - f0), 32'd4);
        check("t4_acc",   32'(acc_cnt - a0), 32'd4);
        step();

        // T3: outstanding limit with responses withheld
        f0 = fire_cnt; rsp_en = 1'b0;
        start_job(32'h2000, 16'h20, 2, 4'hF);
        for (int i = 0; i < 8; i++) push_word($urandom, 4'hF, (i % 4) == 3);
        repeat (10) step();
        check("t3_cap",  32'(fire_cnt - f0), 32'd4);
        check("t3_rdy",  32'(in_ready), 32'd0);
        check("t3_cmdv", 32'(icb_cmd_valid), 32'd0);
        rsp_en = 1'b1;
        step();
        rsp_en = 1'b0;
        step();
        check("t3_more", 32'(icb_cmd_valid), 32'd1);
        step();
        check("t3_cap5", 32'(fire_cnt - f0), 32'd5);
        check("t3_cmdv5", 32'(icb_cmd_valid), 32'd0);
        rsp_en = 1'b1;
        wait_done("t3_done", 300);
        check("t3_fires", 32'(fire_cnt - f0), 32'd8);
        step();

        // T5: zero rows, then an error response within a job
        f0 = fire_cnt;
        start_job(32'h4000, 16'h40, 0, 4'h1);
        check("t5_zero_done", 32'(done), 32'd1);
        check("t5_zero_busy", 32'(busy), 32'd0);
        step();
        check("t5_zero_pulse", 32'(done), 32'd0);
        check("t5_zero_cmds",  32'(fire_cnt - f0), 32'd0);
        err_idx = rsp_cnt + 1;
        start_job(32'h5000, 16'h40, 1, 4'h2);
        for (int i = 0; i < 4; i++) push_word($urandom, 4'hF, i == 3);
        wait_done("t5_done", 200);
        check("t5_err", 32'(err), 32'd1);
        step(); step();
        check("t5_err_hold", 32'(err), 32'd1);
        err_idx = -1;
        start_job(32'h5000, 16'h40, 0, 4'h2);
        check("t5_err_clr", 32'(err), 32'd0);
        step();

        // T6: reset mid-job with two commands outstanding
        f0 = fire_cnt; rsp_en = 1'b0;
        start_job(32'h6000, 16'h80, 2, 4'h4);
        push_word($urandom, 4'hF, 1'b0);
        push_word($urandom, 4'hF, 1'b0);
        wait_fires("t6_two", f0 + 2, 50);
        step();
        rst = 1'b1;
        step();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_rdy",  32'(in_ready), 32'd0);
        check("t6_cmdv", 32'(icb_cmd_valid), 32'd0);
        rst = 1'b0;
        err_idx = rsp_cnt;
        rsp_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            check("t6_late_done", 32'(done), 32'd0);
            check("t6_late_err",  32'(err),  32'd0);
        end
        err_idx = -1;

        // Outstanding count must have restarted at zero; addresses wrap at 2^32
        f0 = fire_cnt; rsp_en = 1'b0;
        start_job(32'hFFFF_FFF8, 16'h100, 1, 4'hF);
        for (int i = 0; i < 4; i++) push_word($urandom, 4'hF, i == 3);
        repeat (10) step();
        check("t6_outcnt", 32'(fire_cnt - f0), 32'd4);
        rsp_en = 1'b1;
        wait_done("t6_wrap_done", 200);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
